// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one access, waits LATENCY cycles,
// then performs a byte-masked read or write and pulses DataMem_Ready.
module data_mem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DataMem_access,
   input  logic        DataMem_RW,
   input  logic [3:0]  DataMem_Select,
   input  logic [31:0] DataMem_Address,
   input  logic [31:0] WriteDataMem,
   output logic [31:0] ReadDataMem,
   output logic        DataMem_Ready,
   output logic        DataMem_Error
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        rw_q;
   logic [3:0]  sel_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [31:0] mem [DEPTH];

   logic [AW-1:0] idx;
   logic          in_range;
   logic          fire;
   logic          mem_we;
   logic [31:0]   bmask;
   logic [31:0]   rd_word;

   assign idx      = addr_q[AW+1:2];
   assign in_range = (addr_q >> (AW + 2)) == 32'd0;
   assign fire     = (state == BUSY) && (cnt == 4'd0);
   assign mem_we   = fire && !rst && rw_q && in_range;
   assign rd_word  = mem[idx];

   assign bmask = {{8{sel_q[3]}}, {8{sel_q[2]}},
                   {8{sel_q[1]}}, {8{sel_q[0]}}};

   // Array is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[idx] <= (rd_word & ~bmask) | (wdata_q & bmask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= 4'd0;
         ReadDataMem   <= 32'd0;
         DataMem_Ready <= 1'b0;
         DataMem_Error <= 1'b0;
      end else begin
         DataMem_Ready <= 1'b0;
         DataMem_Error <= 1'b0;
         unique case (state)
            IDLE: begin
               if (DataMem_access) begin
                  rw_q    <= DataMem_RW;
                  sel_q   <= DataMem_Select;
                  addr_q  <= DataMem_Address;
                  wdata_q <= WriteDataMem;
                  cnt     <= 4'(LATENCY - 1);
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  state         <= DONE;
                  DataMem_Ready <= 1'b1;
                  DataMem_Error <= !in_range;
                  if (!rw_q)
                     ReadDataMem <= in_range ? (rd_word & bmask) : 32'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: scoreboard of expected completions
// filled by the driver, drained by a monitor on every Ready pulse.
module tb_data_mem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;
   localparam int WIN   = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        acc;
   logic        rw;
   logic [3:0]  sel;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rdy;
   logic        err;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DEPTH(DEPTH),
      .LATENCY(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .DataMem_access(acc),
      .DataMem_RW(rw),
      .DataMem_Select(sel),
      .DataMem_Address(addr),
      .WriteDataMem(wdata),
      .ReadDataMem(rdata),
      .DataMem_Ready(rdy),
      .DataMem_Error(err)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          accept;
      logic [31:0] addr;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] ref_mem [int];
   logic [31:0] last_rd = 32'd0;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Reference behaviour: byte-by-byte, straight from the access rules.
   task automatic model(input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        output exp_t e);
      bit          inr;
      int          i;
      logic [31:0] word;
      inr   = a < 32'(4 * DEPTH);
      i     = int'(a / 4);
      e.err = !inr;
      if (w) begin
         if (inr) begin
            word = ref_mem.exists(i) ? ref_mem[i] : 32'd0;
            for (int b = 0; b < 4; b++)
               if (s[b]) word[8*b +: 8] = d[8*b +: 8];
            ref_mem[i] = word;
         end
         e.rdata = last_rd;
      end else begin
         e.rdata = 32'd0;
         if (inr)
            for (int b = 0; b < 4; b++)
               if (s[b]) e.rdata[8*b +: 8] = ref_mem[i][8*b +: 8];
         last_rd = e.rdata;
      end
   endtask

   task automatic access(input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit hold = 1'b0, input bit keep = 1'b0);
      exp_t e;
      int   n;
      if (!hold) @(negedge clk);
      rw    = w;
      sel   = s;
      addr  = a;
      wdata = d;
      acc   = 1'b1;
      model(w, s, a, d, e);
      e.accept = cyc + (hold ? 2 : 1);
      e.addr   = a;
      sbq.push_back(e);
      n = 0;
      @(negedge clk);
      while (!rdy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!rdy) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout addr=%h: got 0 expected 1", a);
      end
      if (!keep) acc = 1'b0;
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      logic [31:0] hold_exp;
      logic        prev;
      exp_t        e;
      hold_exp = 32'd0;
      prev     = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            hold_exp = 32'd0;
            prev     = 1'b0;
         end else if (rdy) begin
            check("ready_not_consecutive", 32'(prev), 32'd0);
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ready: got 1 expected 0");
            end else begin
               e = sbq.pop_front();
               check($sformatf("latency@%h", e.addr),
                     32'(cyc - e.accept), 32'(LAT));
               check($sformatf("rdata@%h", e.addr), rdata, e.rdata);
               check($sformatf("error@%h", e.addr),
                     32'(err), 32'(e.err));
               hold_exp = e.rdata;
            end
            prev = 1'b1;
         end else begin
            check("rdata_hold", rdata, hold_exp);
            prev = 1'b0;
         end
      end
   end

   initial begin
      bit held;
      bit k;
      logic [31:0] a;
      rst   = 1'b1;
      acc   = 1'b0;
      rw    = 1'b0;
      sel   = 4'h0;
      addr  = 32'd0;
      wdata = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_rdata", rdata, 32'd0);
      check("reset_ready", 32'(rdy), 32'd0);
      check("reset_error", 32'(err), 32'd0);
      rst = 1'b0;

      for (int w = 0; w < WIN; w++)
         access(1'b1, 4'hF, 32'(w * 4), $urandom);

      access(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
      access(1'b0, 4'hF, 32'h40, 32'h0);
      access(1'b0, 4'hF, 32'h43, 32'h0);

      access(1'b1, 4'hF, 32'h10, 32'h11223344);
      access(1'b1, 4'b0011, 32'h10, 32'hAABBCCDD);
      access(1'b0, 4'hF, 32'h10, 32'h0);
      access(1'b0, 4'b0100, 32'h10, 32'h0);

      access(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
      access(1'b0, 4'hF, 32'h0, 32'h0);
      access(1'b0, 4'hF, 32'h1000, 32'h0);
      access(1'b1, 4'hF, 32'(4 * DEPTH - 4), 32'h5A5AA5A5);
      access(1'b0, 4'hF, 32'(4 * DEPTH - 1), 32'h0);

      access(1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
      access(1'b0, 4'hF, 32'h4, 32'h0, 1'b1, 1'b0);

      access(1'b1, 4'hF, 32'h20, 32'h0);
      @(negedge clk);
      rw    = 1'b1;
      sel   = 4'hF;
      addr  = 32'h20;
      wdata = 32'hFFFFFFFF;
      acc   = 1'b1;
      @(negedge clk);
      acc     = 1'b0;
      rst     = 1'b1;
      last_rd = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT + 3) begin
         @(negedge clk);
         check("abort_no_ready", 32'(rdy), 32'd0);
      end
      access(1'b0, 4'hF, 32'h20, 32'h0);

      access(1'b1, 4'h0, 32'h8, 32'h12345678);
      access(1'b0, 4'hF, 32'h8, 32'h0);

      held = 1'b0;
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 9) == 0)
            a = 32'(4 * DEPTH) + ($urandom & 32'h0FFF_FFFF);
         else
            a = 32'($urandom_range(0, WIN * 4 - 1));
         k = ($urandom_range(0, 3) == 0);
         access(1'($urandom), 4'($urandom), a, $urandom, held, k);
         held = k;
      end
      acc = 1'b0;

      repeat (10) @(negedge clk);
      check("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
